// File: rtl/hack_rom_loader_if.sv
// Byte-stream, ROM-write and status signals of the HACK boot loader.
// The host drives start and the byte stream; the loader drives everything else.
interface hack_rom_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_load;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [14:0] words_loaded;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, rom_load, rom_addr, rom_data,
        input  cpu_hold, busy, done, error, words_loaded
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, rom_load, rom_addr, rom_data,
        output cpu_hold, busy, done, error, words_loaded
    );
endinterface

// File: rtl/hack_rom_loader.sv
// Boot sequencer for the HACK instruction ROM: receives a length-prefixed,
// checksummed big-endian word stream, writes it to ROM, then releases the CPU.
module hack_rom_loader #(
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    hack_rom_loader_if.slave  bus
);
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN, ERROR
    } state_e;

    state_e         state;
    logic [BW-1:0]  len_hi_q;
    logic [DW-1:0]  len_q;
    logic [BW-1:0]  word_hi_q;
    logic [BW-1:0]  csum_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  words_q;

    logic           rx_ready_q;
    logic           rom_load_q;
    logic [AW-1:0]  rom_addr_q;
    logic [DW-1:0]  rom_data_q;
    logic           cpu_hold_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;

    // Byte handshake and decode of the incoming length / word count.
    logic           accept;
    logic [DW-1:0]  len_in;
    logic           len_bad;
    logic           last_word;

    assign accept    = bus.rx_valid & rx_ready_q;
    assign len_in    = {len_hi_q, bus.rx_data};
    assign len_bad   = (len_in == '0) || (32'(len_in) > MAX_WORDS);
    assign last_word = (DW'(words_q) + DW'(1)) == len_q;

    // Sequencer; every output register is updated on the edge that enters its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            word_hi_q  <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            rx_ready_q <= 1'b0;
            rom_load_q <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            rom_load_q <= 1'b0;
            case (state)
                IDLE, RUN, ERROR: begin
                    if (bus.start) begin
                        state      <= LEN_HI;
                        addr_q     <= '0;
                        words_q    <= '0;
                        csum_q     <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= bus.rx_data;
                        state    <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len_q <= len_in;
                        if (len_bad) begin
                            state      <= ERROR;
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end

                DATA_HI: begin
                    if (accept) begin
                        word_hi_q <= bus.rx_data;
                        csum_q    <= csum_q + bus.rx_data;
                        state     <= DATA_LO;
                    end
                end

                // The write strobe and its address/data are registered here so
                // they are valid for exactly the WRITE cycle.
                DATA_LO: begin
                    if (accept) begin
                        csum_q     <= csum_q + bus.rx_data;
                        rom_load_q <= 1'b1;
                        rom_addr_q <= addr_q;
                        rom_data_q <= {word_hi_q, bus.rx_data};
                        rx_ready_q <= 1'b0;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    addr_q     <= addr_q + AW'(1);
                    words_q    <= words_q + AW'(1);
                    rx_ready_q <= 1'b1;
                    state      <= last_word ? CHECK : DATA_HI;
                end

                CHECK: begin
                    if (accept) begin
                        busy_q     <= 1'b0;
                        rx_ready_q <= 1'b0;
                        if (bus.rx_data == csum_q) begin
                            state      <= RUN;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state   <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.rom_load     = rom_load_q;
    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_data     = rom_data_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader: stimulus queues expected ROM writes and
// load results; a negedge monitor pops and compares them as the DUT produces them.
module tb_hack_rom_loader;
    typedef logic [7:0] byte_q_t[$];
    typedef struct packed { logic [14:0] a; logic [15:0] d; } wr_t;
    typedef struct packed { logic ok; logic [14:0] wl; } res_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    wr_t  wr_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hack_rom_loader_if lif();
    hack_rom_loader #(.MAX_WORDS(16384)) dut (.clk(clk), .rst(rst), .bus(lif.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard = 0;
        bit rdy;
        forever begin
            if (rnd && $urandom_range(0, 2) == 0) begin
                lif.rx_valid = 1'b0;
                lif.rx_data  = 8'($urandom);
                lif.start    = ($urandom_range(0, 1) == 1);
            end else begin
                lif.rx_valid = 1'b1;
                lif.rx_data  = b;
                lif.start    = rnd && ($urandom_range(0, 3) == 0);
            end
            rdy = lif.rx_valid && lif.rx_ready;
            @(posedge clk); #1;
            lif.start = 1'b0;
            if (rdy) break;
            guard++;
            if (guard > 100) begin
                total++; bad++;
                $display("FAIL byte_timeout: byte %0h not accepted in %0d cycles", b, guard);
                break;
            end
        end
    endtask

    task automatic send_stream(input byte_q_t s, input bit rnd);
        foreach (s[i]) send_byte(s[i], rnd);
        lif.rx_valid = 1'b0;
    endtask

    task automatic do_start();
        lif.start = 1'b1;
        @(posedge clk); #1;
        lif.start = 1'b0;
    endtask

    task automatic push_three_writes();
        wr_q.push_back('{a: 15'd0, d: 16'h1234});
        wr_q.push_back('{a: 15'd1, d: 16'hABCD});
        wr_q.push_back('{a: 15'd2, d: 16'h0001});
    endtask

    // Monitor: ROM writes and the rising edge of done/error are scoreboarded.
    initial begin
        logic prev_done = 1'b0;
        logic prev_err  = 1'b0;
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst && lif.rom_load) begin
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", lif.rom_addr, lif.rom_data);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(lif.rom_addr), 32'(w.a));
                    check("wr_data", 32'(lif.rom_data), 32'(w.d));
                end
            end
            if ((lif.done && !prev_done) || (lif.error && !prev_err)) begin
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: done %0b error %0b", lif.done, lif.error);
                end else begin
                    r = res_q.pop_front();
                    check("res_done", 32'(lif.done), 32'(r.ok));
                    check("res_error", 32'(lif.error), 32'(!r.ok));
                    check("res_words", 32'(lif.words_loaded), 32'(r.wl));
                end
            end
            prev_done = lif.done;
            prev_err  = lif.error;
        end
    end

    initial begin
        byte_q_t good = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBF};
        byte_q_t badc = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC0};
        byte_q_t part = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
        int t0;

        rst = 1'b1;
        lif.start = 1'b0; lif.rx_valid = 1'b0; lif.rx_data = 8'h00;
        #12;
        check("rst_cpu_hold", 32'(lif.cpu_hold), 32'd1);
        check("rst_busy", 32'(lif.busy), 32'd0);
        check("rst_rx_ready", 32'(lif.rx_ready), 32'd0);
        check("rst_rom_addr", 32'(lif.rom_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Good load, rx_valid continuously high.
        push_three_writes();
        res_q.push_back('{ok: 1'b1, wl: 15'd3});
        do_start();
        t0 = cyc;
        check("start_busy", 32'(lif.busy), 32'd1);
        send_stream(good, 1'b0);
        check("run_latency", 32'(cyc - t0), 32'd12);
        check("run_done", 32'(lif.done), 32'd1);
        check("run_cpu_hold", 32'(lif.cpu_hold), 32'd0);
        check("run_words", 32'(lif.words_loaded), 32'd3);

        // Restart from RUN with a bad checksum; writes overwrite from address 0.
        push_three_writes();
        res_q.push_back('{ok: 1'b0, wl: 15'd3});
        do_start();
        check("rerun_cpu_hold", 32'(lif.cpu_hold), 32'd1);
        check("rerun_done", 32'(lif.done), 32'd0);
        send_stream(badc, 1'b0);
        check("csum_error", 32'(lif.error), 32'd1);
        check("csum_cpu_hold", 32'(lif.cpu_hold), 32'd1);
        check("csum_done", 32'(lif.done), 32'd0);
        do_start();
        check("restart_error_clr", 32'(lif.error), 32'd0);
        check("restart_rx_ready", 32'(lif.rx_ready), 32'd1);

        // Zero length rejected after LEN_LO, nothing written, no further bytes taken.
        res_q.push_back('{ok: 1'b0, wl: 15'd0});
        send_stream('{8'h00, 8'h00}, 1'b0);
        check("len0_error", 32'(lif.error), 32'd1);
        lif.rx_valid = 1'b1; lif.rx_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        check("len0_rx_ready", 32'(lif.rx_ready), 32'd0);
        lif.rx_valid = 1'b0;

        // Length one past MAX_WORDS (0x4001) rejected.
        res_q.push_back('{ok: 1'b0, wl: 15'd0});
        do_start();
        send_stream('{8'h40, 8'h01}, 1'b0);
        check("lenmax_error", 32'(lif.error), 32'd1);
        check("lenmax_rx_ready", 32'(lif.rx_ready), 32'd0);

        // Random valid gaps and stray start pulses give the same result.
        push_three_writes();
        res_q.push_back('{ok: 1'b1, wl: 15'd3});
        do_start();
        send_stream(good, 1'b1);
        check("rnd_done", 32'(lif.done), 32'd1);
        check("rnd_words", 32'(lif.words_loaded), 32'd3);

        // Async reset during DATA_LO of the second word, then a clean reload.
        wr_q.push_back('{a: 15'd0, d: 16'h1234});
        do_start();
        send_stream(part, 1'b0);
        rst = 1'b1;
        #2;
        check("arst_cpu_hold", 32'(lif.cpu_hold), 32'd1);
        check("arst_busy", 32'(lif.busy), 32'd0);
        check("arst_done", 32'(lif.done), 32'd0);
        check("arst_rx_ready", 32'(lif.rx_ready), 32'd0);
        check("arst_words", 32'(lif.words_loaded), 32'd0);
        check("arst_rom_data", 32'(lif.rom_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_three_writes();
        res_q.push_back('{ok: 1'b1, wl: 15'd3});
        do_start();
        send_stream(good, 1'b0);
        check("reload_done", 32'(lif.done), 32'd1);
        check("reload_cpu_hold", 32'(lif.cpu_hold), 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check("writes_drained", 32'(wr_q.size()), 32'd0);
        check("results_drained", 32'(res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot sequencer for the HACK computer's instruction ROM. It holds the CPU in reset, accepts a length-prefixed, checksummed byte stream, and assembles big-endian 16-bit instruction words. Each word is written into the instruction ROM through the ROM load/address/data lines. On a valid checksum it releases the CPU; on any format or checksum fault it keeps the CPU held and flags an error.

## Interface
- `MAX_WORDS`, default 16384: ROM depth; largest legal word count.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begins a new load when sampled high in IDLE, RUN or ERROR.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader can accept a byte. A byte transfers on a rising edge with `rx_valid & rx_ready`.
- `rom_load` out 1: ROM write strobe; also selects `rom_addr` over the PC at the top level.
- `rom_addr` out 15: ROM write address.
- `rom_data` out 16: ROM write data.
- `cpu_hold` out 1: OR'd with `rst` into the CPU reset.
- `busy` out 1: high in any load state (LEN_HI through CHECK).
- `done` out 1: high in RUN.
- `error` out 1: high in ERROR.
- `words_loaded` out 15: number of words written in the current or most recent load.

## Operation
- Stream format:
  - 2 length bytes: N, high byte first.
  - N data words, 2 bytes each, high byte first.
  - 1 checksum byte: 8-bit sum, mod 256, of all 2N data bytes. Length bytes are excluded.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN, ERROR.
- IDLE/RUN/ERROR + `start` → LEN_HI. On this transition:
  - clear address counter, word counter and checksum;
  - clear `done`/`error`;
  - assert `cpu_hold`.
- `start` is ignored while `busy`.
- LEN_HI accept → LEN_LO.
- LEN_LO accept → validate N:
  - N == 0 or N > `MAX_WORDS` → ERROR;
  - otherwise → DATA_HI.
- DATA_HI accept: latch the high byte, add it to the checksum → DATA_LO.
- DATA_LO accept: latch the low byte, add it to the checksum → WRITE.
- WRITE, exactly one cycle:
  - `rom_load`=1, `rom_addr`=address counter, `rom_data`=assembled word.
  - At the closing edge, address and `words_loaded` increment.
  - Go to CHECK if `words_loaded`+1 == N, else DATA_HI.
- CHECK accept: byte == checksum → RUN, else → ERROR.
- RUN: `cpu_hold`=0 and `done`=1.
- ERROR: `cpu_hold`=1 and `error`=1; holds until `start` or `rst`.
- `rx_ready`=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK. It is 0 in WRITE, IDLE, RUN, ERROR. Bytes offered then are not consumed.
- Arithmetic:
  - Address counter is 15 bits and never wraps, because N ≤ `MAX_WORDS` is checked first.
  - Word comparison is made against the 16-bit N.
  - Checksum is 8 bits and wraps.
- ROM contents written before an ERROR are not cleared.

## Timing
- Reset values:
  - state IDLE; `cpu_hold`=1.
  - `rom_load`, `rx_ready`, `busy`, `done`, `error` all 0.
  - `rom_addr`, `rom_data`, `words_loaded` all 0.
- All outputs are registered or decoded from state only. There is no combinational path from `rx_valid` to `rx_ready`.
- `start` sampled at edge k → LEN_HI and `busy`=1 from cycle k+1.
- With `rx_valid` held high: entry to LEN_HI → RUN takes 2+3N+1 cycles. This is one word per 3 cycles.
- Stalls (`rx_valid`=0) hold the current state indefinitely; no timeout.
- `rom_addr`/`rom_data` hold their last values outside WRITE.
- `rst` mid-load: immediate return to IDLE with `cpu_hold`=1. Partially written ROM is left as is.

## Test plan
- Stream 00 03 12 34 AB CD 00 01 BF with `rx_valid` continuously high:
  - three WRITE pulses with addr/data 0/1234, 1/ABCD, 2/0001;
  - `done`=1 and `cpu_hold`=0 exactly 12 cycles after LEN_HI entry;
  - `words_loaded`=3.
- Same stream with checksum byte C0 → three writes, then `error`=1, `cpu_hold`=1, `done`=0. A following `start` returns to LEN_HI with `error` cleared.
- Length 00 00, and separately length 40 01 with default `MAX_WORDS`:
  - ERROR after LEN_LO;
  - no `rom_load` pulse;
  - `rx_ready`=0 afterwards.
- Three-word stream with `rx_valid` toggled randomly, plus `start` pulsed mid-load → identical ROM writes and result as the first scenario; `start` has no effect.
- Assert `rst` during DATA_LO of word 2 → asynchronous return to IDLE with all reset values; then a fresh `start` and full stream completes normally.
- From RUN, `start` → `cpu_hold` rises the next cycle; `done` clears; the new load overwrites from address 0.
